// File: rtl/wb_conbus_arbiter.sv
// wb_conbus_arbiter: round-robin Wishbone arbiter with a registered, always one-hot grant
module wb_conbus_arbiter #(
    parameter int NUM_MASTERS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] reqs,
    output logic [NUM_MASTERS-1:0] gnt
);
    localparam int N = NUM_MASTERS;
    logic [N-1:0]   cur;
    logic [N-1:0]   nxt;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] base;
    logic [2*N-1:0] pick;
    // Doubling the request vector turns the circular search after the owner into a lowest-set-bit search from base.
    always_comb begin
        dbl  = {reqs, reqs};
        base = {{N{1'b0}}, cur} << 1;
        pick = dbl & ~(dbl - base);
        nxt  = |(reqs & cur) ? cur : |pick ? (pick[N-1:0] | pick[2*N-1:N]) : cur;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) cur <= {{(N-1){1'b0}}, 1'b1} | N'(1);
        else      cur <= nxt;
    assign gnt = cur;
endmodule

// File: tb/tb_wb_conbus_arbiter.sv
// tb_wb_conbus_arbiter: directed vectors plus a reference round-robin model for 8 and 3 masters
module tb_wb_conbus_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] reqs8 = 8'hFF;
    logic [7:0] gnt8;
    logic [2:0] reqs3 = 3'b000;
    logic [2:0] gnt3;
    int         total = 0;
    int         bad = 0;

    wb_conbus_arbiter #(.NUM_MASTERS(8)) dut8 (.clk(clk), .rst(rst), .reqs(reqs8), .gnt(gnt8));
    wb_conbus_arbiter #(.NUM_MASTERS(3)) dut3 (.clk(clk), .rst(rst), .reqs(reqs3), .gnt(gnt3));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rr_next(input int n, input logic [31:0] c, input logic [31:0] r);
        int k = 0;
        for (int i = 0; i < n; i++) if (c[i]) k = i;
        if (r[k]) return c;
        for (int j = 1; j < n; j++) if (r[(k + j) % n]) return 32'd1 << ((k + j) % n);
        return c;
    endfunction

    initial begin
        logic [31:0] e8, e3, o8, o3;
        int w8[8];
        int w3[3];
        int max8 = 0;
        int max3 = 0;
        #12;
        chk("reset8", gnt8, 8'h01);
        chk("reset3", gnt3, 3'b001);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_ff", gnt8, 8'h01);
        end
        for (int i = 0; i < 8; i++) begin
            reqs8 = 8'hFF & ~(8'h01 << i);
            step();
            chk("rotate", gnt8, 8'h01 << ((i + 1) % 8));
        end
        reqs8 = 8'h40; step(); chk("to40", gnt8, 8'h40);
        reqs8 = 8'h05; step(); chk("wrap", gnt8, 8'h01);
        reqs8 = 8'h04; step(); chk("skip", gnt8, 8'h04);
        reqs8 = 8'h10; step(); chk("to10", gnt8, 8'h10);
        reqs8 = 8'h00;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("park", gnt8, 8'h10);
        end
        reqs8 = 8'h08; step(); chk("unpark", gnt8, 8'h08);
        reqs8 = 8'h20; step(); chk("to20", gnt8, 8'h20);
        step(); chk("keep20", gnt8, 8'h20);
        #2 rst = 1'b0;
        #1 chk("async_rst", gnt8, 8'h01);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst", gnt8, 8'h20);
        e8 = 32'h20;
        e3 = 32'h1;
        foreach (w8[i]) w8[i] = 0;
        foreach (w3[i]) w3[i] = 0;
        for (int c = 0; c < 5000; c++) begin
            reqs8 = 8'($urandom);
            reqs3 = 3'($urandom);
            o8 = e8;
            o3 = e3;
            e8 = rr_next(8, e8, {24'd0, reqs8});
            e3 = rr_next(3, e3, {29'd0, reqs3});
            step();
            chk("rand8", gnt8, e8);
            chk("rand3", gnt3, e3);
            chk("onehot8", 32'($onehot(gnt8)), 1);
            chk("onehot3", 32'($onehot(gnt3)), 1);
            for (int i = 0; i < 8; i++) begin
                w8[i] = (!reqs8[i] || e8[i]) ? 0 : w8[i] + ((e8 != o8) ? 1 : 0);
                if (w8[i] > max8) max8 = w8[i];
            end
            for (int i = 0; i < 3; i++) begin
                w3[i] = (!reqs3[i] || e3[i]) ? 0 : w3[i] + ((e3 != o3) ? 1 : 0);
                if (w3[i] > max3) max3 = w3[i];
            end
        end
        chk("starve8", 32'(max8 <= 7), 1);
        chk("starve3", 32'(max3 <= 2), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
